pool2d_frame_gather: RTL and testbench



---
 rtl/pool2d_frame_gather_pkg.sv | 15 +
 rtl/pool2d_frame_gather_if.sv | 23 ++
 rtl/pool2d_frame_gather_bank.sv | 61 ++++++
 rtl/pool2d_frame_gather.sv | 79 +++++++
 tb/tb_pool2d_frame_gather.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pool2d_frame_gather_pkg.sv
// rtl/pool2d_frame_gather_pkg.sv - shared types and helpers for the frame gather stage
package pool2d_frame_gather_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Counter width that stays at least one bit when there is a single beat per frame.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool2d_frame_gather_if.sv
// rtl/pool2d_frame_gather_if.sv - input beat stream and output frame handshake bundle
interface pool2d_frame_gather_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int ELEMS  = 16
);
  logic [LANES-1:0][DATA_W-1:0] data_in_0;
  logic                         data_in_0_valid;
  logic                         data_in_0_ready;
  logic [ELEMS-1:0][DATA_W-1:0] data_out_0;
  logic                         data_out_0_valid;
  logic                         data_out_0_ready;

  modport master (
    output data_in_0, data_in_0_valid, data_out_0_ready,
    input  data_in_0_ready, data_out_0, data_out_0_valid
  );

  modport slave (
    input  data_in_0, data_in_0_valid, data_out_0_ready,
    output data_in_0_ready, data_out_0, data_out_0_valid
  );
endinterface

// File: rtl/pool2d_frame_gather_bank.sv
// rtl/pool2d_frame_gather_bank.sv - one frame bank: storage, write port and full/empty state
module pool2d_frame_bank
  import pool2d_frame_gather_pkg::*;
#(
  parameter int DW    = 8,
  parameter int P     = 1,
  parameter int ELEMS = 16,
  parameter int CW    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [CW-1:0]             i_beat_idx,
  input  logic [P-1:0][DW-1:0]      i_lanes,
  input  logic                      i_set_full,
  input  logic                      i_clr_full,
  output logic [ELEMS-1:0][DW-1:0]  o_data,
  output logic                      o_full
);

  bank_state_e              r_state;
  logic                     r_full;
  logic [ELEMS-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BANK_EMPTY;
      r_full  <= 1'b0;
      r_mem   <= '0;
    end else begin
      // The full guard keeps the frame under read bit-stable while downstream holds it.
      if (i_wr_en && !r_full) begin
        for (int e = 0; e < ELEMS; e++) begin
          if (CW'(e / P) == i_beat_idx) r_mem[e] <= i_lanes[e % P];
        end
      end
      case (r_state)
        BANK_EMPTY: if (i_wr_en) begin
          r_state <= i_set_full ? BANK_FULL : BANK_FILLING;
          r_full  <= i_set_full;
        end
        BANK_FILLING: if (i_wr_en && i_set_full) begin
          r_state <= BANK_FULL;
          r_full  <= 1'b1;
        end
        BANK_FULL: if (i_clr_full) begin
          r_state <= BANK_EMPTY;
          r_full  <= 1'b0;
        end
        default: begin
          r_state <= BANK_EMPTY;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data = r_mem;
  assign o_full = r_full;

endmodule

// File: rtl/pool2d_frame_gather.sv
// rtl/pool2d_frame_gather.sv - raster beat stream into ping-pong frame banks, one frame per output handshake
module pool2d_frame_gather
  import pool2d_frame_gather_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int FRAME_WIDTH                 = 4,
  parameter int FRAME_HEIGHT                = 4
) (
  input logic                  clk,
  input logic                  rst,
  pool2d_frame_gather_if.slave bus
);

  localparam int DW    = DATA_IN_0_PRECISION_0;
  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int ELEMS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int BEATS = ELEMS / P;
  localparam int CW    = cnt_width(BEATS);

  if ((ELEMS % P) != 0 || DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_params
    $fatal(1, "pool2d_frame_gather: frame size must be a multiple of the lane count");
  end

  logic [CW-1:0]            r_beat_cnt;
  logic                     r_wr_sel;
  logic                     r_rd_sel;
  logic [1:0]               w_full;
  logic [ELEMS-1:0][DW-1:0] w_bank_data [2];
  logic                     w_in_ready;
  logic                     w_in_fire;
  logic                     w_last;
  logic                     w_out_fire;

  assign w_in_ready = !rst && !w_full[r_wr_sel];
  assign w_in_fire  = bus.data_in_0_valid && w_in_ready;
  assign w_last     = (r_beat_cnt == CW'(BEATS - 1));
  assign w_out_fire = w_full[r_rd_sel] && bus.data_out_0_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pool2d_frame_bank #(
      .DW(DW), .P(P), .ELEMS(ELEMS), .CW(CW)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_in_fire && (r_wr_sel == 1'(b))),
      .i_beat_idx (r_beat_cnt),
      .i_lanes    (bus.data_in_0),
      .i_set_full (w_in_fire && (r_wr_sel == 1'(b)) && w_last),
      .i_clr_full (w_out_fire && (r_rd_sel == 1'(b))),
      .o_data     (w_bank_data[b]),
      .o_full     (w_full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_last) begin
          r_beat_cnt <= '0;
          r_wr_sel   <= ~r_wr_sel;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
      if (w_out_fire) r_rd_sel <= ~r_rd_sel;
    end
  end

  assign bus.data_in_0_ready  = w_in_ready;
  assign bus.data_out_0       = w_bank_data[r_rd_sel];
  assign bus.data_out_0_valid = w_full[r_rd_sel];

endmodule

// File: tb/tb_pool2d_frame_gather.sv
// tb/tb_pool2d_frame_gather.sv - directed self-checking bench for the frame gather stage
module tb_pool2d_frame_gather;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pool2d_frame_gather_if #(.DATA_W(8), .LANES(1), .ELEMS(16)) if1 ();
  pool2d_frame_gather_if #(.DATA_W(8), .LANES(4), .ELEMS(16)) if4 ();

  pool2d_frame_gather #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(1),
    .FRAME_WIDTH(4), .FRAME_HEIGHT(4)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1));

  pool2d_frame_gather #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(4),
    .FRAME_WIDTH(4), .FRAME_HEIGHT(4)
  ) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] frame(input int base);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[k*8 +: 8] = 8'(base + k);
    return f;
  endfunction

  initial begin
    rst = 1'b1;
    if1.data_in_0 = '0;
    if1.data_in_0_valid = 1'b0;
    if1.data_out_0_ready = 1'b0;
    if4.data_in_0 = '0;
    if4.data_in_0_valid = 1'b0;
    if4.data_out_0_ready = 1'b1;
    step();
    step();
    chk("rst_ready", 128'(if1.data_in_0_ready), 128'(0));
    chk("rst_valid", 128'(if1.data_out_0_valid), 128'(0));
    chk("rst_data", if1.data_out_0, 128'(0));
    chk("rst_valid4", 128'(if4.data_out_0_valid), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(if1.data_in_0_ready), 128'(1));

    // single frame, values 0..15
    if1.data_out_0_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("single_valid_low", 128'(if1.data_out_0_valid), 128'(0));
      if1.data_in_0 = 8'(i);
      if1.data_in_0_valid = 1'b1;
      step();
    end
    if1.data_in_0_valid = 1'b0;
    chk("single_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("single_data", if1.data_out_0, frame(0));
    step();
    chk("single_valid_pulse", 128'(if1.data_out_0_valid), 128'(0));

    // backpressure: two frames with downstream stalled
    if1.data_out_0_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("bp_ready", 128'(if1.data_in_0_ready), 128'(1));
      if1.data_in_0 = (i < 16) ? 8'(i) : 8'(100 + i - 16);
      if1.data_in_0_valid = 1'b1;
      step();
    end
    chk("bp_ready_drop", 128'(if1.data_in_0_ready), 128'(0));
    if1.data_in_0 = 8'd200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_beat33_ready", 128'(if1.data_in_0_ready), 128'(0));
      chk("bp_held_valid", 128'(if1.data_out_0_valid), 128'(1));
      chk("bp_held_data", if1.data_out_0, frame(0));
    end
    if1.data_in_0_valid = 1'b0;
    if1.data_out_0_ready = 1'b1;
    step();
    chk("bp_frame1_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("bp_frame1_data", if1.data_out_0, frame(100));
    step();
    chk("bp_drained_valid", 128'(if1.data_out_0_valid), 128'(0));
    chk("bp_drained_ready", 128'(if1.data_in_0_ready), 128'(1));

    // streaming: 5 frames back to back
    for (int cyc = 0; cyc < 80; cyc++) begin
      chk("stream_ready", 128'(if1.data_in_0_ready), 128'(1));
      chk("stream_valid", 128'(if1.data_out_0_valid), 128'((cyc > 0) && (cyc % 16 == 0)));
      if ((cyc > 0) && (cyc % 16 == 0))
        chk("stream_data", if1.data_out_0, frame(cyc - 16));
      if1.data_in_0 = 8'(cyc);
      if1.data_in_0_valid = 1'b1;
      step();
    end
    if1.data_in_0_valid = 1'b0;
    chk("stream_last_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("stream_last_data", if1.data_out_0, frame(64));
    step();
    chk("stream_end_valid", 128'(if1.data_out_0_valid), 128'(0));

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 7; i++) begin
      if1.data_in_0 = 8'hAA;
      if1.data_in_0_valid = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 128'(if1.data_out_0_valid), 128'(0));
    chk("mid_rst_ready", 128'(if1.data_in_0_ready), 128'(0));
    chk("mid_rst_data", if1.data_out_0, 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if1.data_in_0 = 8'(50 + i);
      step();
    end
    if1.data_in_0_valid = 1'b0;
    chk("mid_rst_frame_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("mid_rst_frame_data", if1.data_out_0, frame(50));
    step();

    // final write into bank 1 coincides with output handshake of bank 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    if1.data_out_0_ready = 1'b0;
    if1.data_in_0_valid = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if1.data_in_0 = (i < 16) ? 8'(32 + i) : 8'(64 + i - 16);
      step();
    end
    chk("sim_pre_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("sim_pre_data", if1.data_out_0, frame(32));
    chk("sim_pre_ready", 128'(if1.data_in_0_ready), 128'(1));
    if1.data_in_0 = 8'(79);
    if1.data_out_0_ready = 1'b1;
    step();
    if1.data_out_0_ready = 1'b0;
    chk("sim_b1_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("sim_b1_data", if1.data_out_0, frame(64));
    for (int i = 0; i < 16; i++) begin
      chk("sim_c_ready", 128'(if1.data_in_0_ready), 128'(1));
      if1.data_in_0 = 8'(96 + i);
      step();
    end
    if1.data_in_0_valid = 1'b0;
    chk("sim_both_full_ready", 128'(if1.data_in_0_ready), 128'(0));
    chk("sim_b1_held", if1.data_out_0, frame(64));
    if1.data_out_0_ready = 1'b1;
    step();
    chk("sim_c_valid", 128'(if1.data_out_0_valid), 128'(1));
    chk("sim_c_data", if1.data_out_0, frame(96));
    step();
    chk("sim_end_valid", 128'(if1.data_out_0_valid), 128'(0));

    // wide lanes: four elements per beat
    for (int b = 0; b < 4; b++) begin
      chk("wide_ready", 128'(if4.data_in_0_ready), 128'(1));
      chk("wide_valid_low", 128'(if4.data_out_0_valid), 128'(0));
      if4.data_in_0 = {8'(4*b + 3), 8'(4*b + 2), 8'(4*b + 1), 8'(4*b)};
      if4.data_in_0_valid = 1'b1;
      step();
    end
    if4.data_in_0_valid = 1'b0;
    chk("wide_valid", 128'(if4.data_out_0_valid), 128'(1));
    chk("wide_data", if4.data_out_0, frame(0));
    step();
    chk("wide_valid_pulse", 128'(if4.data_out_0_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
